// File: rtl/adder_pkg.sv
// Shared types and constant helpers for the pipelined carry adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Widest datapath the saturation helpers can describe.
  localparam int unsigned SatMaxWidth = 1024;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Largest positive two's-complement value of the given width, zero-extended.
  function automatic logic [SatMaxWidth-1:0] sat_max_signed(input int unsigned width);
    logic [SatMaxWidth-1:0] v;
    v = '0;
    for (int unsigned i = 0; i + 1 < width; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of the given width, zero-extended.
  function automatic logic [SatMaxWidth-1:0] sat_min_signed(input int unsigned width);
    logic [SatMaxWidth-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/carry_chunk.sv
// Combinational W-bit ripple adder built from fulladder cells; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module carry_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : bit_g
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_carry_adder.sv
// Add/subtract with the carry chain cut into STAGES registered chunks, valid/ready handshake.
// Define PIPELINED_CARRY_ADDER_SAT_EN to saturate the result on signed overflow.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  op_t              in_op;
  logic [WIDTH-1:0] in_b_eff;
  logic             in_cin_eff;
  logic             adv;

  always_comb begin
    in_op      = op_t'(in_sub);
    in_b_eff   = (in_op == OP_SUB) ? ~in_b : in_b;
    in_cin_eff = (in_op == OP_SUB) ? 1'b1 : in_cin;
  end

  // One enable for the whole pipe: bubbles move, nothing collapses.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stage_g
    localparam int unsigned Lo   = k * CHUNK;
    localparam int unsigned Done = Lo + CHUNK;  // result bits complete after this stage
    localparam int unsigned Rem  = WIDTH - Lo;  // operand bits still unconsumed on entry

    logic             vld_in;
    logic             cin_in;
    logic [Rem-1:0]   a_in;
    logic [Rem-1:0]   b_in;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    logic [Done-1:0]  sum_new;
    logic [Done-1:0]  sum_res;

    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic [Done-1:0]  sum_d, sum_q;

    if (k == 0) begin : src_g
      assign vld_in  = in_valid;
      assign cin_in  = in_cin_eff;
      assign a_in    = in_a;
      assign b_in    = in_b_eff;
      assign sum_new = chunk_sum;
    end else begin : src_g
      assign vld_in  = stage_g[k-1].valid_q;
      assign cin_in  = stage_g[k-1].carry_q;
      assign a_in    = stage_g[k-1].skew_g.a_q;
      assign b_in    = stage_g[k-1].skew_g.b_q;
      assign sum_new = {chunk_sum, stage_g[k-1].sum_q};
    end

    carry_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .a        (a_in[CHUNK-1:0]),
      .b        (b_in[CHUNK-1:0]),
      .cin      (cin_in),
      .sum      (chunk_sum),
      .cout     (chunk_cout),
      .c_msb_in (chunk_c_msb)
    );

    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      if (adv) begin
        valid_d = vld_in;
        carry_d = chunk_cout;
        sum_d   = sum_res;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : skew_g
      // Operand chunks for later stages ride along, shifted so the next chunk sits at bit 0.
      logic [Rem-CHUNK-1:0] a_d, a_q;
      logic [Rem-CHUNK-1:0] b_d, b_q;
      logic                 unused_c_msb;

      assign unused_c_msb = chunk_c_msb;
      assign sum_res      = sum_new;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_in[Rem-1:CHUNK];
          b_d = b_in[Rem-1:CHUNK];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : last_g
      logic ovf_new;
      logic ovf_d, ovf_q;

      assign ovf_new = chunk_c_msb ^ chunk_cout;

`ifdef PIPELINED_CARRY_ADDER_SAT_EN
      localparam logic [SatMaxWidth-1:0] SatMaxFull = sat_max_signed(WIDTH);
      localparam logic [SatMaxWidth-1:0] SatMinFull = sat_min_signed(WIDTH);

      // a_in[CHUNK-1] is the original sign of A; B has already been inverted.
      always_comb begin
        sum_res = sum_new;
        if (ovf_new) begin
          sum_res = a_in[CHUNK-1] ? SatMinFull[WIDTH-1:0] : SatMaxFull[WIDTH-1:0];
        end
      end
`else
      assign sum_res = sum_new;
`endif

      always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
          ovf_d = ovf_new;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign out_valid = valid_q;
      assign out_sum   = sum_q;
      assign out_cout  = carry_q;
      assign out_ovf   = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder: directed corner beats, backpressure,
// asynchronous mid-stream reset and a randomized stream against an arithmetic reference.
module tb_pipelined_carry_adder;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  always #5 clk = ~clk;

  pipelined_carry_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  int           n_checks  = 0;
  int           n_fail    = 0;
  int           cyc       = 0;
  int           n_drained = 0;
  exp_t         exp_q[$];
  logic         prev_stall = 1'b0;
  logic         last_valid;
  logic         last_in_ready;
  logic         last_acc;
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] be;
    logic         ce;
    exp_t         e;
    be     = sub ? ~b : b;
    ce     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
`ifdef PIPELINED_CARRY_ADDER_SAT_EN
    if (e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 6))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_FFFF;
      4:       return W'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, account for the coming posedge.
  task automatic do_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    cyc++;
    last_valid    = out_valid;
    last_in_ready = in_ready;
    last_sum      = out_sum;
    last_cout     = out_cout;
    last_ovf      = out_ovf;
    if (exp_q.size() == 0) begin
      check_eq("no_spurious_valid", out_valid, 1'b0);
    end else if (out_valid) begin
      check_eq("out_sum", out_sum, exp_q[0].sum);
      check_eq("out_cout", out_cout, exp_q[0].cout);
      check_eq("out_ovf", out_ovf, exp_q[0].ovf);
      if (ordy) begin
        void'(exp_q.pop_front());
        n_drained++;
      end
    end else if (prev_stall) begin
      check_eq("valid_held_in_stall", out_valid, 1'b1);
    end
    prev_stall = out_valid && !ordy;
    last_acc   = v && in_ready;
    if (last_acc) exp_q.push_back(model(a, b, cin, sub));
  endtask

  task automatic single_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub, input logic [W-1:0] esum,
                             input logic ecout, input logic eovf);
    int   lat;
    logic seen;
    do_cycle(1'b1, a, b, cin, sub, 1'b1);
    check_eq({tag, "_accept"}, last_acc, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 4 * S) begin
      do_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      lat++;
      seen = last_valid;
    end
    check_eq({tag, "_latency"}, lat, S);
    check_eq({tag, "_sum"}, last_sum, esum);
    check_eq({tag, "_cout"}, last_cout, ecout);
    check_eq({tag, "_ovf"}, last_ovf, eovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   i;
    int   d0;
    int   k;
    logic stall;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_sum", out_sum, '0);
    check_eq("rst_out_cout", out_cout, 1'b0);
    check_eq("rst_out_ovf", out_ovf, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    single_beat("chunk_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0001_0000, 1'b0, 1'b0);
    single_beat("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
                32'h0000_0000, 1'b1, 1'b0);
    single_beat("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single_beat("sub_cin_ignored", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
`ifdef PIPELINED_CARRY_ADDER_SAT_EN
    single_beat("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    single_beat("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
    single_beat("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single_beat("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif

    // Backpressure: 8 beats a=b=i, out_ready low while the pipe is full (t=5..8).
    t  = 0;
    i  = 0;
    k  = 0;
    d0 = n_drained;
    while ((i < 8 || n_drained - d0 < 8) && t < 60) begin
      stall = (t >= 5 && t <= 8);
      do_cycle(i < 8, W'(i), W'(i), 1'b0, 1'b0, !stall);
      check_eq("bp_in_ready", last_in_ready, !stall);
      if (last_valid && !stall) begin
        check_eq("bp_in_order", last_sum, W'(2 * k));
        k++;
      end
      if (last_acc) i++;
      t++;
    end
    check_eq("bp_count", n_drained - d0, 8);

    // Asynchronous reset with the pipe full and a result at the output.
    for (int j = 0; j < 6; j++) do_cycle(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1);
    check_eq("pre_reset_valid", last_valid, 1'b1);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_out_sum", out_sum, '0);
    check_eq("mid_rst_out_cout", out_cout, 1'b0);
    check_eq("mid_rst_out_ovf", out_ovf, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) do_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    single_beat("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
                32'h2345_6789, 1'b0, 1'b0);

    // Randomized stream with random bubbles and backpressure.
    for (int j = 0; j < 400; j++) begin
      do_cycle($urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      do_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      t++;
    end
    check_eq("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
